// File: rtl/bios_copier.sv
// bios_copier: boot-time copy of the BIOS ROM into main memory.
// Reads every ROM word in order (1-cycle ROM latency) and issues one write per
// word on a we/ack port, holding address and data stable until acknowledged.
// A write that is not acknowledged within ACK_TIMEOUT cycles parks the block
// in ERR with a sticky err flag until the next start.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | rom_addr presented; ROM samples it at the end of this cycle
// S_WAIT  | rom_data valid; latch word/address and raise mem_we
// S_WRITE | mem_we held until mem_ack or the ack timer expires
// S_DONE  | one-cycle done pulse after the last word was acknowledged
// S_ERR   | ack timeout seen; err held high until start
module bios_copier #(
    parameter int          WORDS       = 128,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  rom_addr,
    input  logic [47:0] rom_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The ack timer is a down-counter loaded with ACK_TIMEOUT-1 on entry to
    // WRITE; reaching zero without an ack ends the last permitted cycle.
    localparam int              TW    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0]   TLOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [6:0]      LAST  = 7'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    index_q, index_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    rom_addr_q, rom_addr_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // The ROM's upper 16 bits carry nothing the copier needs.
    logic unused_rom_hi;
    assign unused_rom_hi = ^rom_data[47:32];

    assign rom_addr  = rom_addr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // State and registered outputs; synchronous reset aborts any copy at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            timer_q     <= '0;
            rom_addr_q  <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            timer_q     <= timer_d;
            rom_addr_q  <= rom_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        timer_d     = timer_q;
        rom_addr_d  = rom_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_FETCH;
                    index_d    = '0;
                    rom_addr_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                mem_wdata_d = rom_data[31:0];
                mem_addr_d  = BASE_ADDR + {23'd0, index_q, 2'b00};
                mem_we_d    = 1'b1;
                timer_d     = TLOAD;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                // An ack on the final permitted cycle still counts as a write.
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    if (index_q == LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        index_d    = index_q + 7'd1;
                        rom_addr_d = index_q + 7'd1;
                        state_d    = S_FETCH;
                    end
                end else if (timer_q == '0) begin
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_ERR;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_WRITE);
    end

endmodule
